// File: rtl/nreg_burst_if.sv
// nreg_burst_if: serial valid/ready source and sink bundle for the burst buffer
//   in_valid/in_bit/in_ready    : source side, bit accepted when in_valid && in_ready
//   out_valid/out_bit/out_ready : sink side, bit transferred when out_valid && out_ready
//   slave modport is the controller view, master modport is the producer/consumer view
interface nreg_burst_if;
    logic in_valid, in_bit, in_ready, out_valid, out_bit, out_ready;
    modport master(output in_valid, in_bit, out_ready, input in_ready, out_valid, out_bit);
    modport slave(input in_valid, in_bit, out_ready, output in_ready, out_valid, out_bit);
endinterface

// File: rtl/nreg_burst_ctrl.sv
// nreg_burst_ctrl: N-bit FIFO-ordered burst buffer built on a controlled single-bit shift chain
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a burst (IDLE only);  flush : stop filling early (FILL only)
//   bus        : serial source/sink handshake (slave modport)
//   count      : bits held;  busy : not IDLE;  done : one-cycle burst-complete pulse
module nreg_burst_ctrl #(
    parameter int N = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          flush,
    nreg_burst_if.slave   bus,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, FILL, ALIGN, DRAIN} state_t;
    localparam logic [CW-1:0] NC = CW'(N);
    state_t        state;
    logic [N-1:0]  stage;
    logic [N-1:0]  nxt;
    logic [CW-1:0] pad;
    logic [CW-1:0] cnt_acc;
    logic          acc;
    logic          xfer;
    logic          shift;
    always_comb begin
        acc     = state == FILL && bus.in_valid;
        xfer    = state == DRAIN && bus.out_ready;
        cnt_acc = count + CW'(acc);
        shift   = acc || state == ALIGN || xfer;
        // padding and drain both shift in zeros; only accepted bits carry data
        nxt[0]  = acc & bus.in_bit;
        for (int k = 1; k < N; k++) nxt[k] = stage[k-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            count <= '0;
            pad   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift) stage <= nxt;
            case (state)
                IDLE: if (start) state <= FILL;
                FILL: begin
                    // flush is judged on the count after this cycle's accept
                    count <= cnt_acc;
                    if (cnt_acc == NC) state <= DRAIN;
                    else if (flush) begin
                        if (cnt_acc == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= ALIGN;
                            pad   <= NC - cnt_acc;
                        end
                    end
                end
                // push the oldest bit up to stage[N-1] so the drain reads from a fixed tap
                ALIGN: begin
                    pad <= pad - CW'(1);
                    if (pad == CW'(1)) state <= DRAIN;
                end
                DRAIN: if (xfer) begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == FILL;
    assign bus.out_valid = state == DRAIN;
    assign bus.out_bit   = stage[N-1];
    assign busy          = state != IDLE;
endmodule

// File: tb/tb_nreg_burst_ctrl.sv
// tb_nreg_burst_ctrl: directed + random bench for nreg_burst_ctrl at N = 1, 4, 8 against a queue model
module tb_nreg_burst_ctrl;
    localparam int NS [3] = '{1, 4, 8};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] st = '0, fl = '0, iv = '0, ib = '0, orr = '0;
    logic [2:0] ir, ov, ob, by, dn;
    logic [3:0] cnt [3];
    int nchk = 0;
    int nfail = 0;
    int ph [3];
    int n [3];
    int pd [3];
    logic m [3][8];
    logic de [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int NN = NS[g];
        nreg_burst_if bi();
        logic [$clog2(NN+1)-1:0] c;
        assign bi.in_valid  = iv[g];
        assign bi.in_bit    = ib[g];
        assign bi.out_ready = orr[g];
        nreg_burst_ctrl #(.N(NN)) dut (
            .clk(clk), .rst_n(rst_n), .start(st[g]), .flush(fl[g]), .bus(bi),
            .count(c), .busy(by[g]), .done(dn[g])
        );
        assign ir[g]  = bi.in_ready;
        assign ov[g]  = bi.out_valid;
        assign ob[g]  = bi.out_bit;
        assign cnt[g] = 4'(c);
    end

    task automatic chk(string tag, int i, logic [7:0] got, logic [7:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s n=%0d got %0h expected %0h", tag, NS[i], got, exp);
        end
    endtask

    // model phases: 0 idle, 1 collecting, 2 padding, 3 replaying; m holds the bits in arrival order
    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; n[i] = 0; pd[i] = 0; de[i] = 1'b0;
        end
    endtask

    task automatic mstep(int i);
        de[i] = 1'b0;
        case (ph[i])
            0: if (st[i]) ph[i] = 1;
            1: begin
                if (iv[i]) begin
                    m[i][n[i]] = ib[i];
                    n[i]++;
                end
                if (n[i] == NS[i]) ph[i] = 3;
                else if (fl[i]) begin
                    if (n[i] == 0) begin
                        ph[i] = 0; de[i] = 1'b1;
                    end else begin
                        ph[i] = 2; pd[i] = NS[i] - n[i];
                    end
                end
            end
            2: begin
                pd[i]--;
                if (pd[i] == 0) ph[i] = 3;
            end
            default: if (orr[i]) begin
                for (int k = 0; k < 7; k++) m[i][k] = m[i][k+1];
                n[i]--;
                if (n[i] == 0) begin
                    ph[i] = 0; de[i] = 1'b1;
                end
            end
        endcase
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("in_ready", i, 8'(ir[i]), 8'(ph[i] == 1));
            chk("out_valid", i, 8'(ov[i]), 8'(ph[i] == 3));
            chk("busy", i, 8'(by[i]), 8'(ph[i] != 0));
            chk("count", i, 8'(cnt[i]), 8'(n[i]));
            chk("done", i, 8'(dn[i]), 8'(de[i]));
            if (ph[i] == 3) chk("out_bit", i, 8'(ob[i]), 8'(m[i][0]));
        end
    endtask

    task automatic rchk();
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, 8'(ir[i]), 8'd0);
            chk("rst_out_valid", i, 8'(ov[i]), 8'd0);
            chk("rst_out_bit", i, 8'(ob[i]), 8'd0);
            chk("rst_count", i, 8'(cnt[i]), 8'd0);
            chk("rst_busy", i, 8'(by[i]), 8'd0);
            chk("rst_done", i, 8'(dn[i]), 8'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) for (int i = 0; i < 3; i++) mstep(i);
        else mreset();
        @(negedge clk);
        check_all();
    endtask

    // reset asserted between edges must clear outputs without waiting for a clock
    task automatic areset();
        #2 rst_n = 1'b0;
        #1 mreset();
        rchk();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drv(int i, logic s, logic f, logic v, logic b, logic r);
        st[i] = s; fl[i] = f; iv[i] = v; ib[i] = b; orr[i] = r;
    endtask

    initial begin
        logic [3:0] b4;
        logic [6:0] pat;
        logic [7:0] b8;
        mreset();
        @(negedge clk);
        rchk();
        rst_n = 1'b1;
        // N=4: full burst 1,0,1,1 with in_valid and out_ready held high
        b4 = 4'b1011;
        drv(1, 1, 0, 0, 0, 1); tick();
        for (int k = 3; k >= 0; k--) begin drv(1, 0, 0, 1, b4[k], 1); tick(); end
        drv(1, 0, 0, 1, 0, 1); repeat (6) tick();
        // N=4: accept 1,0 then flush, two pad cycles
        drv(1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 1, 1, 0); tick();
        drv(1, 0, 0, 1, 0, 0); tick();
        drv(1, 0, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 1); repeat (6) tick();
        // N=4: drain 1,1,0,1 under out_ready 1,0,0,1,0,1,1
        b4 = 4'b1101;
        pat = 7'b1001011;
        drv(1, 1, 0, 0, 0, 0); tick();
        for (int k = 3; k >= 0; k--) begin drv(1, 0, 0, 1, b4[k], 0); tick(); end
        for (int k = 6; k >= 0; k--) begin drv(1, 0, 0, 0, 0, pat[k]); tick(); end
        drv(1, 0, 0, 0, 0, 0); repeat (2) tick();
        // N=4: accept and flush together at count 2, then flush at count 0
        drv(1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 1, 1, 0); tick();
        drv(1, 0, 0, 1, 0, 0); tick();
        drv(1, 0, 1, 1, 1, 0); tick();
        drv(1, 0, 0, 0, 0, 1); repeat (5) tick();
        drv(1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 0); repeat (2) tick();
        // N=8: reset after three transfers, then replay 10110011
        b8 = 8'b10110100;
        drv(2, 1, 0, 0, 0, 0); tick();
        for (int k = 7; k >= 0; k--) begin drv(2, 0, 0, 1, b8[k], 0); tick(); end
        drv(2, 0, 0, 0, 0, 1); repeat (3) tick();
        areset();
        b8 = 8'b10110011;
        drv(2, 1, 0, 0, 0, 0); tick();
        for (int k = 7; k >= 0; k--) begin drv(2, 0, 0, 1, b8[k], 0); tick(); end
        drv(2, 0, 0, 0, 0, 1); repeat (10) tick();
        // N=1: back-to-back bursts 1 then 0, start held high outside IDLE
        drv(0, 1, 0, 0, 0, 0); tick();
        drv(0, 1, 0, 1, 1, 0); tick();
        drv(0, 1, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        drv(0, 1, 0, 0, 0, 0); tick();
        drv(0, 1, 0, 1, 0, 1); tick();
        drv(0, 1, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0, 0); repeat (2) tick();
        // random traffic on all three depths with occasional asynchronous resets
        repeat (3000) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  = $urandom_range(0, 3) == 0;
                fl[i]  = $urandom_range(0, 7) == 0;
                iv[i]  = $urandom_range(0, 3) != 0;
                ib[i]  = 1'($urandom_range(0, 1));
                orr[i] = $urandom_range(0, 2) != 0;
            end
            if ($urandom_range(0, 499) == 0) areset();
            else tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/nreg_burst_ctrl.md
# nreg_burst_ctrl

Controller that sequences an N-stage single-bit register chain as a burst buffer: it collects up to N serial bits from a valid/ready source, then replays them first-in-first-out to a valid/ready sink. It owns the chain's shift enable and shift input, so no stage moves except under its control. It sits between a serial producer and consumer wherever the team needs an N-bit holding buffer with explicit flow control instead of a free-running delay line.

## Interface
- N, default 8: chain depth in bits, N >= 1.
- CW, derived as clog2(N+1), not overridable: width of `count`.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a burst. Honored in IDLE only.
- flush  input  1  ends filling early. Honored in FILL only.
- in_valid  input  1  source has a bit.
- in_bit  input  1  source data.
- in_ready  output  1  controller accepts a bit.
- out_valid  output  1  controller presents a bit.
- out_bit  output  1  sink data.
- out_ready  input  1  sink accepts a bit.
- count  output  CW  bits currently held, 0..N.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- Internal chain is stage[0..N-1]. A shift does stage[0] <= shin and stage[i] <= stage[i-1]. With no shift, all stages hold.
- States are IDLE, FILL, ALIGN and DRAIN. Reset enters IDLE, clears all stages, and sets pad counter = 0.
- IDLE:
  - `start` moves to FILL.
  - `in_ready` = 0 and `out_valid` = 0.
- FILL:
  - `in_ready` = 1.
  - Accept when `in_valid` && `in_ready`: shift with shin = `in_bit`, then count += 1.
  - When count reaches N after an accept, go to DRAIN.
  - On `flush`: if the post-accept count is 0, go to IDLE and pulse `done`. If it is between 1 and N-1, go to ALIGN with pad counter = N - count.
  - `flush` and an accept in the same cycle: the bit is accepted first, then `flush` is evaluated on the updated count.
  - `flush` in the same cycle the count reaches N is ignored; go to DRAIN.
- ALIGN:
  - Shift with shin = 0 once per cycle and decrement the pad counter.
  - `count` is unchanged.
  - `in_ready` = 0 and `out_valid` = 0.
  - Leave for DRAIN on the cycle the pad counter goes from 1 to 0.
- DRAIN:
  - `out_valid` = 1 and `out_bit` = stage[N-1].
  - On `out_valid` && `out_ready`: shift with shin = 0, then count -= 1.
  - When count goes from 1 to 0, go to IDLE and pulse `done` in that same transfer cycle.
  - While `out_ready` is low, the chain holds and `out_bit` is stable.
- `start` outside IDLE is ignored. `flush` outside FILL is ignored.
- Output order equals input order in all cases. Padding never appears on `out_bit`.

## Timing
- All outputs are registered or decoded from registered state. Nothing combinational runs from inputs to outputs.
- Reset values: `in_ready` = 0, `out_valid` = 0, `out_bit` = 0, `count` = 0, `busy` = 0, `done` = 0.
- `start` seen at edge k: `busy` and `in_ready` are 1 from cycle k+1.
- Full fill with no stalls: N accept cycles, then `out_valid` = 1 on the next cycle.
- Flush at count c (1 ≤ c < N): exactly N - c ALIGN cycles, then DRAIN with `out_valid` = 1.
- Drain with `out_ready` held high: one bit per cycle, `done` on the cycle of the last transfer, IDLE on the next cycle.
- Minimum burst turnaround: `start` may be asserted in the cycle after `done`.
- `rst_n` low at any time, including mid-FILL, mid-ALIGN or mid-DRAIN: immediately return all outputs to their reset values and clear the chain. No `done` pulse is generated.

## Test plan
- N=4. `start`, then bits 1,0,1,1 with `in_valid` held high, `out_ready` high. Required: `in_ready` drops after the 4th accept, `out_bit` sequence is 1,0,1,1 on 4 consecutive cycles, `done` pulses with the 4th transfer, `count` returns to 0.
- N=4. Accept 1,0, then `flush`. Required: 2 ALIGN cycles with `out_valid` = 0, then outputs 1,0, then `done`. No 0 pads are emitted.
- N=4. During DRAIN of 1,1,0,1, toggle `out_ready` as 1,0,0,1,0,1,1. Required: transfers only on `out_ready` = 1, `out_bit` stable while stalled, sequence 1,1,0,1.
- N=4. Accept a bit and assert `flush` in the same cycle at count 2. Required: post-accept count = 3, 1 ALIGN cycle, then 3 bits out in order. Separately, `flush` at count 0 → IDLE with `done` and no output.
- N=8. Assert `rst_n` low mid-DRAIN after 3 transfers. Required: all outputs go to 0 at once, `busy` = 0, no `done`. The next `start` with bits 10110011 replays exactly 10110011.
- N=1. Run a burst of bit 1, then a burst of bit 0 started the cycle after the first `done`. Required: outputs 1 then 0, two `done` pulses, `start` pulses received while not in IDLE have no effect.
